// File: rtl/ir_scan_sequencer.sv
// ir_scan_sequencer: IR capture/shift sequencing with length and opcode checks, BYPASS fallback.
// Optional bad-scan counter port err_count is enabled by defining IR_SEQ_ERRCNT_EN.
module ir_scan_sequencer #(
  parameter int IR_SIZE = 3,
  parameter int CNT_W = 4,
  parameter logic [2**IR_SIZE-1:0] LEGAL_MASK = 8'hBD
) (
  input  logic               clockIR,
  input  logic               reset_bar,
  input  logic               shiftIR,
  input  logic               scan_in,
  output logic               scan_out,
  output logic [IR_SIZE-1:0] instr_out,
  output logic               instr_valid,
  output logic               len_err,
  output logic               opcode_err,
  output logic [CNT_W-1:0]   bit_count
`ifdef IR_SEQ_ERRCNT_EN
  ,
  output logic [7:0]         err_count
`endif
);
  typedef enum logic [2:0] {IDLE, CAPTURED, SHIFT, EXACT, OVER} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] IR_N = CNT_W'(IR_SIZE);
  state_t state_q, state_d;
  logic [IR_SIZE-1:0] scan_q, scan_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic last_err_q, last_err_d, err_next, legal;
`ifdef IR_SEQ_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
`endif
  // State, scan register, counters; everything clears on async reset.
  always_ff @(posedge clockIR or negedge reset_bar) begin
    if (!reset_bar) begin
      state_q    <= IDLE;
      scan_q     <= '0;
      cnt_q      <= '0;
      last_err_q <= 1'b0;
`ifdef IR_SEQ_ERRCNT_EN
      err_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      scan_q     <= scan_d;
      cnt_q      <= cnt_d;
      last_err_q <= last_err_d;
`ifdef IR_SEQ_ERRCNT_EN
      err_cnt_q  <= err_cnt_d;
`endif
    end
  end
  // Next state: a shift advances the scan and classifies its length; a capture reloads
  // the pattern carrying the verdict on the scan that just ended.
  always_comb begin
    legal      = LEGAL_MASK[scan_q];
    err_next   = (state_q == IDLE) ? last_err_q : (state_q == EXACT) ? !legal : 1'b1;
    cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    scan_d     = '0;
    scan_d[0]  = 1'b1;
    scan_d[2]  = err_next;
    cnt_d      = '0;
    state_d    = CAPTURED;
    last_err_d = err_next;
    if (shiftIR) begin
      scan_d     = {scan_in, scan_q[IR_SIZE-1:1]};
      cnt_d      = cnt_inc;
      state_d    = (cnt_inc < IR_N) ? SHIFT : (cnt_inc == IR_N) ? EXACT : OVER;
      last_err_d = last_err_q;
    end
`ifdef IR_SEQ_ERRCNT_EN
    err_cnt_d  = (!shiftIR && err_next && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
`endif
  end
  assign scan_out    = scan_q[0];
  assign instr_valid = (state_q == EXACT) && legal;
  assign instr_out   = instr_valid ? scan_q : {IR_SIZE{1'b1}};
  assign len_err     = (state_q != EXACT) && (state_q != IDLE);
  assign opcode_err  = (state_q == EXACT) && !legal;
  assign bit_count   = cnt_q;
`ifdef IR_SEQ_ERRCNT_EN
  assign err_count   = err_cnt_q;
`endif
endmodule

// File: tb/tb_ir_scan_sequencer.sv
// tb_ir_scan_sequencer: directed checks of capture status, length/opcode checks and reset.
module tb_ir_scan_sequencer;
  logic clockIR = 1'b0;
  logic reset_bar = 1'b0;
  logic shiftIR = 1'b0;
  logic scan_in = 1'b0;
  logic scan_out, instr_valid, len_err, opcode_err;
  logic [2:0] instr_out;
  logic [3:0] bit_count;
  int n_chk = 0;
  int n_fail = 0;
`ifdef IR_SEQ_ERRCNT_EN
  logic [7:0] err_count;
`endif

  ir_scan_sequencer dut (
    .clockIR(clockIR), .reset_bar(reset_bar), .shiftIR(shiftIR), .scan_in(scan_in),
    .scan_out(scan_out), .instr_out(instr_out), .instr_valid(instr_valid),
    .len_err(len_err), .opcode_err(opcode_err), .bit_count(bit_count)
`ifdef IR_SEQ_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clockIR = ~clockIR;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic sh, input logic din);
    shiftIR = sh;
    scan_in = din;
    @(posedge clockIR);
    #1;
  endtask

  task automatic legal_scan(input string tag, input logic status);
    tick(1'b0, 1'b0);
    chk({tag, "_cap_out"}, 16'(scan_out), 16'd1);
    chk({tag, "_cap_cnt"}, 16'(bit_count), 16'd0);
    tick(1'b1, 1'b0);
    chk({tag, "_out_b1"}, 16'(scan_out), 16'd0);
    tick(1'b1, 1'b1);
    chk({tag, "_status"}, 16'(scan_out), 16'(status));
    tick(1'b1, 1'b0);
    chk({tag, "_instr"}, 16'(instr_out), 16'h2);
    chk({tag, "_valid"}, 16'(instr_valid), 16'd1);
  endtask

  initial begin
    #2;
    chk("rst_instr", 16'(instr_out), 16'h7);
    chk("rst_valid", 16'(instr_valid), 16'd0);
    chk("rst_out", 16'(scan_out), 16'd0);
    chk("rst_cnt", 16'(bit_count), 16'd0);
    chk("rst_len", 16'(len_err), 16'd0);
    chk("rst_op", 16'(opcode_err), 16'd0);
`ifdef IR_SEQ_ERRCNT_EN
    chk("rst_errcnt", 16'(err_count), 16'd0);
`endif
    @(posedge clockIR);
    #1 reset_bar = 1'b1;
    // Test 2: first scan after reset, status 0, opcode 010
    tick(1'b0, 1'b0);
    chk("t2_cap_out", 16'(scan_out), 16'd1);
    chk("t2_cap_len", 16'(len_err), 16'd1);
    tick(1'b1, 1'b0);
    chk("t2_out1", 16'(scan_out), 16'd0);
    tick(1'b1, 1'b1);
    chk("t2_out2", 16'(scan_out), 16'd0);
    tick(1'b1, 1'b0);
    chk("t2_instr", 16'(instr_out), 16'h2);
    chk("t2_valid", 16'(instr_valid), 16'd1);
    chk("t2_cnt", 16'(bit_count), 16'd3);
    chk("t2_len", 16'(len_err), 16'd0);
    chk("t2_op", 16'(opcode_err), 16'd0);
    // Test 3: illegal opcode 110
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk("t3_status", 16'(scan_out), 16'd0);
    tick(1'b1, 1'b1);
    chk("t3_op", 16'(opcode_err), 16'd1);
    chk("t3_instr", 16'(instr_out), 16'h7);
    chk("t3_valid", 16'(instr_valid), 16'd0);
    chk("t3_len", 16'(len_err), 16'd0);
    legal_scan("t3_next", 1'b1);
    // Test 4: over-length scan (4 shifts)
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("t4_len", 16'(len_err), 16'd1);
    chk("t4_instr", 16'(instr_out), 16'h7);
    chk("t4_valid", 16'(instr_valid), 16'd0);
    chk("t4_op", 16'(opcode_err), 16'd0);
    chk("t4_cnt", 16'(bit_count), 16'd4);
    legal_scan("t4_next", 1'b1);
    legal_scan("t4_clean", 1'b0);
    // Zero-length scan: capture straight after capture
    tick(1'b0, 1'b0);
    legal_scan("zero_len", 1'b1);
    // Saturation: 17 shifts, OVER stays sticky at count 15
    tick(1'b0, 1'b0);
    for (int i = 0; i < 17; i++) tick(1'b1, 1'b1);
    chk("sat_cnt", 16'(bit_count), 16'hF);
    chk("sat_len", 16'(len_err), 16'd1);
    chk("sat_instr", 16'(instr_out), 16'h7);
    legal_scan("sat_next", 1'b1);
    // Test 5: reset mid-scan (after a bad-scan status was pending)
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    reset_bar = 1'b0;
    #1;
    chk("t5_instr", 16'(instr_out), 16'h7);
    chk("t5_valid", 16'(instr_valid), 16'd0);
    chk("t5_out", 16'(scan_out), 16'd0);
    chk("t5_cnt", 16'(bit_count), 16'd0);
    chk("t5_len", 16'(len_err), 16'd0);
    #1 reset_bar = 1'b1;
    legal_scan("t5_next", 1'b0);
    // Shift from IDLE counts as the first bit
    reset_bar = 1'b0;
    #1 reset_bar = 1'b1;
    tick(1'b1, 1'b1);
    chk("idle_cnt", 16'(bit_count), 16'd1);
    chk("idle_len", 16'(len_err), 16'd1);
    chk("idle_out", 16'(scan_out), 16'd0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("idle_status", 16'(scan_out), 16'd1);
`ifdef IR_SEQ_ERRCNT_EN
    // Test 6: 300 zero-length scans saturate the error counter
    reset_bar = 1'b0;
    #1 reset_bar = 1'b1;
    chk("t6_clr", 16'(err_count), 16'd0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("t6_one", 16'(err_count), 16'd1);
    for (int i = 0; i < 300; i++) tick(1'b0, 1'b0);
    chk("t6_sat", 16'(err_count), 16'd255);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
